// File: rtl/gerador_frequencia_param_pkg.sv
// gerador_frequencia_param_pkg: shared state encodings, default divisors and clog2 helper
package gerador_frequencia_param_pkg;
  typedef enum logic [1:0] {
    OCIOSO         = 2'd0,
    CONTANDO       = 2'd1,
    TROCA_PENDENTE = 2'd2
  } estado_t;
  localparam int CONT_W_PADRAO = 29;
  localparam int N_SEL_PADRAO = 4;
  localparam logic [N_SEL_PADRAO*CONT_W_PADRAO-1:0] DIVS_PADRAO =
    {29'd300000000, 29'd100000000, 29'd50000000, 29'd25000000};
  function automatic int clog2(input int v);
    for (int r = 0; r < 32; r++)
      if ((1 << r) >= v) return r;
    return 32;
  endfunction
endpackage

// File: rtl/gerador_frequencia_param_sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchroniser for the selector switches
// Only elaborated when SYNC_SELETOR_EN is defined, since nothing else uses it.
`ifdef SYNC_SELETOR_EN
module sincronizador_2ff #(
  parameter int W = 1
) (
  input  logic         clock_inicial,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meio;
  always_ff @(posedge clock_inicial or posedge reset)
    if (reset) {q, meio} <= '0;
    else {q, meio} <= {meio, d};
endmodule
`endif

// File: rtl/gerador_frequencia_param.sv
// gerador_frequencia_param: selectable clock divider producing a tick and a 50% square wave
// Define SYNC_SELETOR_EN to pass seletor through a two-flop synchroniser.
module gerador_frequencia_param
  import gerador_frequencia_param_pkg::*;
#(
  parameter int                        CONT_W         = CONT_W_PADRAO,
  parameter int                        N_SEL          = N_SEL_PADRAO,
  parameter int                        SEL_W          = 2,
  parameter logic [N_SEL*CONT_W-1:0]   DIVS           = DIVS_PADRAO,
  parameter bit                        TROCA_IMEDIATA = 1'b0
) (
  input  logic              clock_inicial,
  input  logic              reset,
  input  logic              habilita,
  input  logic [SEL_W-1:0]  seletor,
  output logic              pulso_saida,
  output logic              onda_saida,
  output logic [CONT_W-1:0] contagem,
  output logic [SEL_W-1:0]  sel_ativo,
  output logic              troca_pendente,
  output logic              erro_sel
);
  if (N_SEL < 2 || N_SEL > 16 || SEL_W < clog2(N_SEL)) begin : g_param_invalido
    $error("gerador_frequencia_param: invalid N_SEL/SEL_W");
  end
  estado_t estado, estado_n;
  logic [SEL_W-1:0] sel_s, sel_n;
  logic [CONT_W-1:0] div_a, cont_n;
  logic pulso_n, onda_n, valido, muda, term;
`ifdef SYNC_SELETOR_EN
  sincronizador_2ff #(.W(SEL_W)) u_sinc (
    .clock_inicial(clock_inicial),
    .reset(reset),
    .d(seletor),
    .q(sel_s)
  );
`else
  assign sel_s = seletor;
`endif
  assign div_a = DIVS[int'(sel_ativo)*CONT_W +: CONT_W];
  assign valido = int'(sel_s) < N_SEL;
  assign muda = valido && sel_s != sel_ativo;
  assign term = contagem == div_a - 1'b1;
  always_ff @(posedge clock_inicial or posedge reset)
    if (reset) begin
      estado      <= OCIOSO;
      contagem    <= '0;
      pulso_saida <= 1'b0;
      onda_saida  <= 1'b0;
      sel_ativo   <= '0;
      erro_sel    <= 1'b0;
    end else begin
      estado      <= estado_n;
      contagem    <= cont_n;
      pulso_saida <= pulso_n;
      onda_saida  <= onda_n;
      sel_ativo   <= sel_n;
      erro_sel    <= !valido;
    end
  // A deferred change that coincides with the terminal count is adopted on that same edge.
  always_comb begin
    estado_n = estado;
    sel_n    = sel_ativo;
    cont_n   = contagem;
    pulso_n  = 1'b0;
    onda_n   = onda_saida;
    if (!habilita) begin
      estado_n = OCIOSO;
      sel_n    = muda ? sel_s : sel_ativo;
      cont_n   = muda ? '0 : contagem;
    end else if (TROCA_IMEDIATA && muda) begin
      estado_n = CONTANDO;
      sel_n    = sel_s;
      cont_n   = '0;
    end else begin
      cont_n   = term ? '0 : contagem + 1'b1;
      pulso_n  = term;
      onda_n   = onda_saida ^ term;
      sel_n    = (term && muda) ? sel_s : sel_ativo;
      estado_n = (muda && !term) ? TROCA_PENDENTE : CONTANDO;
    end
  end
  always_comb troca_pendente = estado == TROCA_PENDENTE;
endmodule
